// File: rtl/truth_table_sweeper.sv
// Self-check sequencer for F = A(CD+B) + BC': walks all 16 {A,B,C,D} vectors,
// captures F per vector and scores the result against a golden truth table.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// SETTLE | abcd_out driven, waiting SETTLE_CYCLES for f_in to settle
// SAMPLE | capture f_in into table_out[idx], advance or finish
// DONE   | one-cycle done pulse, pass updated, vector returns to 0
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [15:0] GOLDEN        = 16'hF830
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       miss;

  assign miss = f_in ^ GOLDEN[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      abcd_out     <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= 16'd0;
      mismatch_cnt <= 5'd0;
      pass         <= 1'b0;
      idx          <= 4'd0;
      cnt          <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            table_out    <= 16'd0;
            mismatch_cnt <= 5'd0;
            idx          <= 4'd0;
            abcd_out     <= 4'd0;
            busy         <= 1'b1;
            cnt          <= 4'd0;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            abcd_out <= 4'd0;
            pass     <= 1'b0;
            cnt      <= 4'd0;
          end else if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          // abort beats capture, including on the final vector
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            abcd_out <= 4'd0;
            pass     <= 1'b0;
            cnt      <= 4'd0;
          end else begin
            table_out[idx] <= f_in;
            mismatch_cnt   <= mismatch_cnt + 5'(miss);
            if (idx == 4'd15) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (mismatch_cnt == 5'd0) && !miss;
            end else begin
              idx      <= idx + 4'd1;
              abcd_out <= idx + 4'd1;
              cnt      <= 4'd0;
              state    <= SETTLE;
            end
          end
        end
        DONE: begin
          abcd_out <= 4'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: function-block models on f_in, randomized
// response masks and abort points, scored against a truth-table reference.
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLDEN_REF = 16'hF830;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0, f_in0;
  logic [3:0]  abcd0;
  logic        busy0, done0, pass0;
  logic [15:0] table0;
  logic [4:0]  mis0;
  logic        start1 = 1'b0, abort1 = 1'b0, f_in1;
  logic [3:0]  abcd1;
  logic        busy1, done1, pass1;
  logic [15:0] table1;
  logic [4:0]  mis1;

  int          checks = 0;
  int          errors = 0;
  int          f_mode = 0;
  logic [15:0] rmask = 16'd0;
  logic        exp_pass = 1'b0;

  always #5 clk = ~clk;

  // Reference function block, straight from the boolean equation
  function automatic logic f_ref(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & ((c & d) | b)) | (b & ~c);
  endfunction

  function automatic logic drive_f(input int mode, input logic [3:0] v, input logic [15:0] m);
    case (mode)
      0:       return f_ref(v);
      1:       return 1'b0;
      2:       return ~f_ref(v);
      default: return m[v];
    endcase
  endfunction

  assign f_in0 = drive_f(f_mode, abcd0, rmask);
  assign f_in1 = f_ref(abcd1);

  truth_table_sweeper dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f_in0),
    .abcd_out(abcd0), .busy(busy0), .done(done0), .table_out(table0),
    .mismatch_cnt(mis0), .pass(pass0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f_in1),
    .abcd_out(abcd1), .busy(busy1), .done(done1), .table_out(table1),
    .mismatch_cnt(mis1), .pass(pass1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] expected_table(input int mode, input logic [15:0] m);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = drive_f(mode, 4'(i), m);
    return t;
  endfunction

  // One full sweep on dut0 with vector-sequence, latency and result checks
  task automatic run_sweep(input int mode, input logic [15:0] m, input bit noisy_start);
    logic [15:0] exp_tbl;
    int          exp_mis;
    int          c;
    bit          seq_ok;
    f_mode  = mode;
    rmask   = m;
    exp_tbl = expected_table(mode, m);
    exp_mis = $countones(exp_tbl ^ GOLDEN_REF);
    start0  = 1'b1;
    step();
    start0  = 1'b0;
    c = 0;
    seq_ok = 1'b1;
    while (done0 !== 1'b1 && c < 200) begin
      if (abcd0 !== 4'(c / 4) || busy0 !== 1'b1 || pass0 !== exp_pass) seq_ok = 1'b0;
      if (noisy_start) start0 = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    start0 = 1'b0;
    checks++; if (c !== 64) begin errors++; $display("FAIL sweep_latency got %0d want 64", c); end
    checks++; if (!seq_ok) begin errors++; $display("FAIL sweep_sequence abcd/busy/pass wrong during sweep mode %0d", mode); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", busy0); end
    checks++; if (table0 !== exp_tbl) begin errors++; $display("FAIL table got %h want %h", table0, exp_tbl); end
    checks++; if (mis0 !== 5'(exp_mis)) begin errors++; $display("FAIL mismatch got %0d want %0d", mis0, exp_mis); end
    exp_pass = (exp_mis == 0);
    checks++; if (pass0 !== exp_pass) begin errors++; $display("FAIL pass got %b want %b", pass0, exp_pass); end
    step();
    checks++; if (done0 !== 1'b0 || abcd0 !== 4'd0) begin
      errors++; $display("FAIL after_done done=%b abcd=%0d want 0/0", done0, abcd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++; if ({abcd0, busy0, done0, table0, mis0, pass0} !== '0) begin
      errors++; $display("FAIL reset_outputs got abcd=%0d busy=%b done=%b table=%h mis=%0d pass=%b want all 0",
                          abcd0, busy0, done0, table0, mis0, pass0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_pass = 1'b0;
  endtask

  task automatic test_correct();
    run_sweep(0, 16'd0, 1'b0);
    checks++; if (table0 !== 16'hF830 || mis0 !== 5'd0 || pass0 !== 1'b1) begin
      errors++; $display("FAIL correct_result table=%h mis=%0d pass=%b want f830/0/1", table0, mis0, pass0);
    end
  endtask

  task automatic test_zero();
    run_sweep(1, 16'd0, 1'b0);
    checks++; if (table0 !== 16'h0000 || mis0 !== 5'd7 || pass0 !== 1'b0) begin
      errors++; $display("FAIL zero_result table=%h mis=%0d pass=%b want 0000/7/0", table0, mis0, pass0);
    end
  endtask

  task automatic test_inverted();
    run_sweep(2, 16'd0, 1'b0);
    checks++; if (table0 !== 16'h07CF || mis0 !== 5'd16 || pass0 !== 1'b0) begin
      errors++; $display("FAIL inverted_result table=%h mis=%0d pass=%b want 07cf/16/0", table0, mis0, pass0);
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) run_sweep(3, 16'($urandom), 1'b1);
  endtask

  // Abort once the vector reaches v, after `off` further cycles within it
  task automatic test_abort(input int mode, input logic [15:0] m, input int v, input int off);
    logic [15:0] exp_tbl, lm;
    int          c;
    bit          quiet;
    f_mode  = mode;
    rmask   = m;
    exp_tbl = expected_table(mode, m);
    lm      = 16'((32'd1 << v) - 1);
    start0  = 1'b1;
    step();
    start0  = 1'b0;
    c = 0;
    while (abcd0 !== 4'(v) && c < 200) begin step(); c++; end
    checks++; if (c >= 200) begin errors++; $display("FAIL abort_reach abcd=%0d want %0d", abcd0, v); end
    repeat (off) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    exp_pass = 1'b0;
    checks++; if (busy0 !== 1'b0 || abcd0 !== 4'd0 || done0 !== 1'b0 || pass0 !== 1'b0) begin
      errors++; $display("FAIL abort_outputs busy=%b abcd=%0d done=%b pass=%b want 0/0/0/0", busy0, abcd0, done0, pass0);
    end
    checks++; if (table0 !== (exp_tbl & lm)) begin
      errors++; $display("FAIL abort_table got %h want %h", table0, exp_tbl & lm);
    end
    checks++; if (mis0 !== 5'($countones((exp_tbl ^ GOLDEN_REF) & lm))) begin
      errors++; $display("FAIL abort_mismatch got %0d want %0d", mis0, $countones((exp_tbl ^ GOLDEN_REF) & lm));
    end
    quiet = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (done0 !== 1'b0 || busy0 !== 1'b0 || table0 !== (exp_tbl & lm)) quiet = 1'b0;
      step();
    end
    checks++; if (!quiet) begin errors++; $display("FAIL abort_quiet activity after abort table=%h", table0); end
  endtask

  task automatic test_abort_idle();
    abort0 = 1'b1;
    repeat (3) step();
    abort0 = 1'b0;
    checks++; if (busy0 !== 1'b0 || pass0 !== exp_pass) begin
      errors++; $display("FAIL abort_idle busy=%b pass=%b want 0/%b", busy0, pass0, exp_pass);
    end
  endtask

  task automatic test_reset_mid();
    f_mode = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat ($urandom_range(10, 50)) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({abcd0, busy0, done0, table0, mis0, pass0} !== '0) begin
      errors++; $display("FAIL reset_mid got abcd=%0d busy=%b table=%h mis=%0d pass=%b want all 0",
                          abcd0, busy0, table0, mis0, pass0);
    end
    step();
    rst_n = 1'b1;
    exp_pass = 1'b0;
    step();
    run_sweep(0, 16'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c;
    f_mode = 0;
    start0 = 1'b1;
    c = 0;
    while (done0 !== 1'b1 && c < 200) begin step(); c++; end
    for (int k = 0; k < 2; k++) begin
      step();
      c = 1;
      while (done0 !== 1'b1 && c < 200) begin step(); c++; end
      checks++; if (c !== 66) begin errors++; $display("FAIL b2b_period got %0d want 66", c); end
      checks++; if (table0 !== GOLDEN_REF || pass0 !== 1'b1) begin
        errors++; $display("FAIL b2b_result table=%h pass=%b want f830/1", table0, pass0);
      end
    end
    start0 = 1'b0;
    exp_pass = 1'b1;
    step();
    step();
  endtask

  task automatic test_settle1();
    int c;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    c = 0;
    while (done1 !== 1'b1 && c < 200) begin step(); c++; end
    checks++; if (c !== 32) begin errors++; $display("FAIL settle1_latency got %0d want 32", c); end
    checks++; if (table1 !== GOLDEN_REF || mis1 !== 5'd0 || pass1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL settle1_result table=%h mis=%0d pass=%b busy=%b want f830/0/1/0", table1, mis1, pass1, busy1);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_zero();
    test_inverted();
    test_random(4);
    test_abort(0, 16'd0, 5, 0);
    run_sweep(0, 16'd0, 1'b0);
    for (int k = 0; k < 3; k++)
      test_abort(3, 16'($urandom), $urandom_range(1, 14), $urandom_range(0, 3));
    test_abort(0, 16'd0, 15, 3);
    test_abort_idle();
    test_reset_mid();
    test_back_to_back();
    test_settle1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer for the 4-input combinational function F = A(CD+B) + BC'. It drives all 16 {A,B,C,D} combinations into the circuit in order and waits a programmable settle time per vector. It captures F into a 16-bit truth-table register and compares the result against a golden signature. It is the on-chip self-check controller that sits beside the function block and reports pass/fail with a start/done handshake.

Parameters:
SETTLE_CYCLES, 3, clock cycles abcd_out is held before F is sampled; legal range 1..15.
GOLDEN, 16'hF830, expected truth table; bit i = F for {A,B,C,D} = i.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  synchronous cancel of a running sweep
f_in  input  1  F output of the function block under control
abcd_out  output  4  vector to function block; [3]=A, [2]=B, [1]=C, [0]=D
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
table_out  output  16  captured truth table; bit i = F sampled for vector i
mismatch_cnt  output  5  number of bits where table_out differs from GOLDEN (0..16)
pass  output  1  high when the last completed sweep had mismatch_cnt == 0

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): state IDLE, abcd_out=0, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0, internal idx=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE: at the edge where start=1, clear table_out and mismatch_cnt, set idx=0, abcd_out=0, busy=1, counter=0, and go to SETTLE. pass holds its previous value until DONE.
- SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles per vector.
- SAMPLE (1 cycle, abcd_out stable): table_out[idx] <= f_in; mismatch_cnt increments if f_in != GOLDEN[idx].
  - If idx == 15, go to DONE.
  - Otherwise idx++, abcd_out <= idx+1, counter=0, and return to SETTLE.
- DONE (1 cycle): done=1, busy=0, pass <= (final mismatch_cnt == 0), abcd_out <= 0, then go to IDLE. The mismatch from the last SAMPLE is included in pass.
- Latency: with start seen at edge k, DONE is entered at edge k + 16*(SETTLE_CYCLES+1), which is k+64 at default. IDLE is re-entered one edge later.
- start while busy or in DONE: ignored, with no restart or extension.
- abort=1 in SETTLE or SAMPLE: next edge goes to IDLE with busy=0, abcd_out=0, no done pulse, and pass=0. table_out and mismatch_cnt hold their partial values, and no capture occurs on that edge. abort is ignored in IDLE and DONE. If abort and the final SAMPLE coincide, abort wins.
- abcd_out changes only on SAMPLE→SETTLE, IDLE→SETTLE, DONE→IDLE, and abort/reset. It never glitches mid-vector.
- mismatch_cnt saturates naturally at 16; the 5-bit width is sufficient.

Test Plan:
1. Correct function block on f_in, start pulse → abcd_out steps 0..15, each held 4 cycles; done at start edge +64; table_out=16'hF830, mismatch_cnt=0, pass=1.
2. f_in tied 0 → table_out=16'h0000, mismatch_cnt=7, pass=0, done timing unchanged.
3. f_in = ~F → table_out=16'h07CF, mismatch_cnt=16, pass=0.
4. abort asserted while abcd_out=5 → busy=0 and abcd_out=0 next cycle, no done pulse, pass=0, table_out bits 5..15 still 0; a subsequent start gives a full sweep with pass=1.
5. rst_n pulled low mid-sweep between clock edges → all outputs 0 immediately, with no waiting for clk; after release, start runs a clean sweep.
6. start held high continuously → back-to-back sweeps with a done pulse every 66 cycles; start pulses during busy cause no disturbance; SETTLE_CYCLES=1 override gives done at start edge +32.
